// File: rtl/conv_stream_src_if.sv
// rtl/conv_stream_src_if.sv - valid/ready word stream between source and convolver
interface conv_stream_src_if #(
   parameter int DATA_WIDTH = 8
);
   logic                         tvalid;
   logic                         tready;
   logic signed [DATA_WIDTH-1:0] tdata;

   modport master (output tvalid, output tdata, input tready);
   modport slave  (input tvalid, input tdata, output tready);
endinterface

// File: rtl/conv_stream_src.sv
// rtl/conv_stream_src.sv - loads X/F frames from a host and replays them on two independent streams
module conv_stream_src #(
   parameter int DATA_WIDTH_X = 8,
   parameter int DATA_WIDTH_F = 8,
   parameter int X_SIZE       = 128,
   parameter int F_SIZE       = 32
) (
   input  logic                                 i_clk,
   input  logic                                 i_reset,
   input  logic                                 i_ld_en,
   input  logic                                 i_ld_sel,
   input  logic [$clog2(X_SIZE)-1:0]            i_ld_addr,
   input  logic [((DATA_WIDTH_X > DATA_WIDTH_F) ?
                  DATA_WIDTH_X : DATA_WIDTH_F)-1:0] i_ld_data,
   input  logic                                 i_start,
   output logic                                 o_busy,
   output logic                                 o_done,
   conv_stream_src_if.master                    m_x,
   conv_stream_src_if.master                    m_f
);
   localparam int AW_X = $clog2(X_SIZE);
   localparam int AW_F = (F_SIZE > 1) ? $clog2(F_SIZE) : 1;
   localparam logic [31:0] X_LIM = X_SIZE;
   localparam logic [31:0] F_LIM = F_SIZE;
   localparam logic [AW_X-1:0] X_LAST = AW_X'(X_SIZE - 1);
   localparam logic [AW_F-1:0] F_LAST = AW_F'(F_SIZE - 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_SEND,
      S_DONE
   } state_t;

   logic signed [DATA_WIDTH_X-1:0] r_xarr [X_SIZE];
   logic signed [DATA_WIDTH_F-1:0] r_farr [F_SIZE];

   state_t            r_state;
   logic              r_busy;
   logic              r_done;
   logic              r_vld_x;
   logic              r_vld_f;
   logic              r_cdone_x;
   logic              r_cdone_f;
   logic [AW_X-1:0]   r_idx_x;
   logic [AW_F-1:0]   r_idx_f;

   logic [31:0]       w_ld_addr32;
   logic              w_beat_x;
   logic              w_beat_f;
   logic              w_last_x;
   logic              w_last_f;
   logic              w_fin_x;
   logic              w_fin_f;

   assign w_ld_addr32 = 32'(i_ld_addr);

   // Frame storage is never reset so a loaded frame survives a mid-frame abort.
   always_ff @(posedge i_clk) begin
      if (i_ld_en && !r_busy) begin
         if (!i_ld_sel) begin
            if (w_ld_addr32 < X_LIM)
               r_xarr[i_ld_addr] <= i_ld_data[DATA_WIDTH_X-1:0];
         end else if (w_ld_addr32 < F_LIM) begin
            r_farr[i_ld_addr[AW_F-1:0]] <= i_ld_data[DATA_WIDTH_F-1:0];
         end
      end
   end

   assign m_x.tvalid = r_vld_x;
   assign m_x.tdata  = r_xarr[r_idx_x];
   assign m_f.tvalid = r_vld_f;
   assign m_f.tdata  = r_farr[r_idx_f];

   assign w_beat_x = r_vld_x & m_x.tready;
   assign w_beat_f = r_vld_f & m_f.tready;
   assign w_last_x = (r_idx_x == X_LAST);
   assign w_last_f = (r_idx_f == F_LAST);

   // Look ahead to the final beat so done lands in the cycle right after it.
   assign w_fin_x = r_cdone_x | (w_beat_x & w_last_x);
   assign w_fin_f = r_cdone_f | (w_beat_f & w_last_f);

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_state   <= S_IDLE;
         r_busy    <= 1'b0;
         r_done    <= 1'b0;
         r_vld_x   <= 1'b0;
         r_vld_f   <= 1'b0;
         r_cdone_x <= 1'b0;
         r_cdone_f <= 1'b0;
         r_idx_x   <= '0;
         r_idx_f   <= '0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (i_start) begin
                  r_state   <= S_SEND;
                  r_busy    <= 1'b1;
                  r_vld_x   <= 1'b1;
                  r_vld_f   <= 1'b1;
                  r_cdone_x <= 1'b0;
                  r_cdone_f <= 1'b0;
                  r_idx_x   <= '0;
                  r_idx_f   <= '0;
               end
            end
            S_SEND: begin
               if (w_beat_x) begin
                  if (w_last_x) begin
                     r_vld_x   <= 1'b0;
                     r_cdone_x <= 1'b1;
                  end else begin
                     r_idx_x <= r_idx_x + 1'b1;
                  end
               end
               if (w_beat_f) begin
                  if (w_last_f) begin
                     r_vld_f   <= 1'b0;
                     r_cdone_f <= 1'b1;
                  end else begin
                     r_idx_f <= r_idx_f + 1'b1;
                  end
               end
               if (w_fin_x && w_fin_f) begin
                  r_state <= S_DONE;
                  r_done  <= 1'b1;
               end
            end
            S_DONE: begin
               r_state <= S_IDLE;
               r_busy  <= 1'b0;
            end
            default: begin
               r_state <= S_IDLE;
               r_busy  <= 1'b0;
            end
         endcase
      end
   end

   assign o_busy = r_busy;
   assign o_done = r_done;
endmodule
